mem_sdp_param: RTL and testbench

- Parametrised simple-dual-port synchronous RAM. It is the next generation of the team's 8-bit x 64 single-port scratch memory.
- Adds configurable width and depth, separate read and write ports, byte-lane write enables, write-first bypass, a read-valid strobe, and a post-reset clear sweep FSM.
- Sits between core datapath blocks and their local storage; one clock domain.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_sdp_array.sv | 55 +++++
 rtl/mem_sdp_param.sv | 162 ++++++++++++++++
 tb/tb_mem_sdp_param.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the simple-dual-port RAM family.
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    function automatic int lane_count(input int width);
        return width / 8;
    endfunction

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/mem_sdp_array.sv
// Bare storage array: byte-lane write port, unregistered read port.
// Build option MEM_SDP_PARITY_EN adds one stored even-parity bit per lane.
module mem_sdp_array
    import mem_pkg::*;
#(
    parameter int    WIDTH     = 8,
    parameter int    DEPTH     = 64,
    parameter string INIT_FILE = "",
    localparam int   AW        = $clog2(DEPTH),
    localparam int   LANES     = lane_count(WIDTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [LANES-1:0] wbe,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
`ifdef MEM_SDP_PARITY_EN
    ,
    output logic [LANES-1:0] rpar
`endif
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

`ifdef MEM_SDP_PARITY_EN
    logic [LANES-1:0] par [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wbe[i]) begin
                    par[waddr][i] <= even_parity(din[8*i +: 8]);
                end
            end
        end
    end

    assign rpar = par[raddr];
`endif

endmodule

// File: rtl/mem_sdp_param.sv
// Parametrised simple-dual-port RAM with byte lanes, write-first bypass and
// a post-reset clear sweep. Define MEM_SDP_PARITY_EN for per-lane parity.
module mem_sdp_param
    import mem_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               DEPTH        = 64,
    parameter int               CLEAR_ON_RST = 1,
    parameter logic [WIDTH-1:0] CLR_VAL      = '0,
    parameter string            INIT_FILE    = "",
    localparam int              AW           = $clog2(DEPTH),
    localparam int              LANES        = lane_count(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [AW-1:0]    waddr,
    input  logic [LANES-1:0] wbe,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    output logic             busy,
    output logic             perr
);

    localparam logic CLEAR_EN = (CLEAR_ON_RST != 0);

    state_t           state;
    state_t           state_nx;
    logic [AW-1:0]    cnt;

    logic             arr_we;
    logic [AW-1:0]    arr_waddr;
    logic [LANES-1:0] arr_wbe;
    logic [WIDTH-1:0] arr_din;
    logic [WIDTH-1:0] arr_rdata;

    logic [LANES-1:0] hit;
    logic [WIDTH-1:0] rd_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR_EN ? ST_CLEAR : ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_CLEAR) begin
                cnt <= cnt + AW'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_CLEAR: if (cnt == AW'(DEPTH - 1)) state_nx = ST_IDLE;
            ST_IDLE:  state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_CLEAR) || (rst && CLEAR_EN);

    // The sweep owns the write port; rst itself never writes the array.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = waddr;
        arr_wbe   = wbe;
        arr_din   = din;
        if (!rst) begin
            case (state)
                ST_CLEAR: begin
                    arr_we    = 1'b1;
                    arr_waddr = cnt;
                    arr_wbe   = '1;
                    arr_din   = CLR_VAL;
                end
                ST_IDLE: arr_we = wr;
            endcase
        end
    end

    // Write-first: lanes being written this cycle come straight from din.
    always_comb begin
        hit     = '0;
        rd_word = arr_rdata;
        for (int i = 0; i < LANES; i++) begin
            hit[i] = wr && (waddr == raddr) && wbe[i];
            if (hit[i]) begin
                rd_word[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout   <= '0;
            dvalid <= 1'b0;
        end else if (state == ST_IDLE && rd) begin
            dout   <= rd_word;
            dvalid <= 1'b1;
        end else begin
            dvalid <= 1'b0;
        end
    end

`ifdef MEM_SDP_PARITY_EN
    logic [LANES-1:0] arr_rpar;
    logic [LANES-1:0] lane_bad;
    logic             perr_q;

    always_comb begin
        lane_bad = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_bad[i] = (even_parity(arr_rdata[8*i +: 8]) != arr_rpar[i]) && !hit[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (state == ST_IDLE && rd) begin
            perr_q <= |lane_bad;
        end
    end

    assign perr = perr_q;

    mem_sdp_array #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .INIT_FILE(INIT_FILE)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .waddr(arr_waddr),
        .wbe  (arr_wbe),
        .din  (arr_din),
        .raddr(raddr),
        .rdata(arr_rdata),
        .rpar (arr_rpar)
    );
`else
    assign perr = 1'b0;

    mem_sdp_array #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .INIT_FILE(INIT_FILE)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .waddr(arr_waddr),
        .wbe  (arr_wbe),
        .din  (arr_din),
        .raddr(raddr),
        .rdata(arr_rdata)
    );
`endif

endmodule

// File: tb/tb_mem_sdp_param.sv
// Scoreboard bench for mem_sdp_param (WIDTH=32, DEPTH=64, clear sweep on).
module tb_mem_sdp_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr = 1'b0;
    logic [5:0]  waddr = '0;
    logic [3:0]  wbe = '0;
    logic [31:0] din = '0;
    logic        rd = 1'b0;
    logic [5:0]  raddr = '0;
    logic [31:0] dout;
    logic        dvalid;
    logic        busy;
    logic        perr;

    mem_sdp_param #(
        .WIDTH       (32),
        .DEPTH       (64),
        .CLEAR_ON_RST(1),
        .CLR_VAL     (32'h0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .waddr (waddr),
        .wbe   (wbe),
        .din   (din),
        .rd    (rd),
        .raddr (raddr),
        .dout  (dout),
        .dvalid(dvalid),
        .busy  (busy),
        .perr  (perr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        perr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_model [64];
    logic [3:0]  bad_model [64];
    logic        m_clear = 1'b0;
    int          m_cnt = 0;
    logic        exp_dv = 1'b0;
    logic [31:0] last_dout = '0;
    logic        last_perr = 1'b0;
    logic        mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, then advances the reference model past the
    // coming posedge so the monitor can compare right after it.
    task automatic apply_stimulus(input logic r, input logic w, input logic [5:0] wa,
                                  input logic [3:0] be, input logic [31:0] d,
                                  input logic rdi, input logic [5:0] ra);
        logic [31:0] ew;
        logic        ep;
        @(negedge clk);
        rst = r; wr = w; waddr = wa; wbe = be; din = d; rd = rdi; raddr = ra;
        #1;
        check_output("busy", {31'b0, busy}, {31'b0, (r ? 1'b1 : m_clear)});
        exp_dv = 1'b0;
        if (r) begin
            m_clear   = 1'b1;
            m_cnt     = 0;
            last_dout = '0;
            last_perr = 1'b0;
        end else if (m_clear) begin
            mem_model[m_cnt] = '0;
            bad_model[m_cnt] = '0;
            if (m_cnt == 63) m_clear = 1'b0;
            m_cnt++;
        end else begin
            if (rdi) begin
                ew = mem_model[ra];
                ep = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (w && wa == ra && be[i]) ew[8*i +: 8] = d[8*i +: 8];
                    else if (bad_model[ra][i]) ep = 1'b1;
                end
                sb.push_back('{data: ew, perr: ep});
                exp_dv    = 1'b1;
                last_dout = ew;
                last_perr = ep;
            end
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem_model[wa][8*i +: 8] = d[8*i +: 8];
                        bad_model[wa][i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 6'd0, 4'h0, 32'h0, 1'b0, 6'd0);
    endtask

    task automatic do_write(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
        apply_stimulus(1'b0, 1'b1, a, be, d, 1'b0, 6'd0);
    endtask

    task automatic do_read(input logic [5:0] a);
        apply_stimulus(1'b0, 1'b0, 6'd0, 4'h0, 32'h0, 1'b1, a);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en) begin
            check_output("dvalid", {31'b0, dvalid}, {31'b0, exp_dv});
            if (exp_dv && sb.size() > 0) begin
                e = sb.pop_front();
                check_output("dout", dout, e.data);
                check_output("perr", {31'b0, perr}, {31'b0, e.perr});
            end else begin
                check_output("dout_hold", dout, last_dout);
                check_output("perr_hold", {31'b0, perr}, {31'b0, last_perr});
            end
        end
    end

    initial begin
        // Power-up reset, two cycles, then the full sweep with blocked traffic.
        apply_stimulus(1'b1, 1'b0, 6'd0, 4'h0, 32'h0, 1'b0, 6'd0);
        mon_en = 1'b1;
        apply_stimulus(1'b1, 1'b0, 6'd0, 4'h0, 32'h0, 1'b0, 6'd0);
        idle(10);
        apply_stimulus(1'b0, 1'b1, 6'd3, 4'hF, 32'h55, 1'b0, 6'd0);
        apply_stimulus(1'b0, 1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd3);
        idle(55);

        for (int a = 0; a < 64; a++) do_read(6'(a));

        do_write(6'd5, 4'b1111, 32'hDEADBEEF);
        do_write(6'd5, 4'b0011, 32'h00001122);
        do_read(6'd5);

        do_write(6'd9, 4'b1111, 32'hAAAAAAAA);
        apply_stimulus(1'b0, 1'b1, 6'd9, 4'b0101, 32'h12345678, 1'b1, 6'd9);
        idle(1);
        do_read(6'd9);

        apply_stimulus(1'b0, 1'b1, 6'd10, 4'hF, 32'hCAFEF00D, 1'b1, 6'd5);
        do_read(6'd10);
        do_write(6'd5, 4'b0000, 32'hFFFFFFFF);
        do_read(6'd5);

        for (int k = 0; k < 200; k++) begin
            apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                           4'($urandom), $urandom, 1'($urandom_range(0, 1)),
                           6'($urandom_range(0, 7)));
        end

`ifdef MEM_SDP_PARITY_EN
        do_write(6'd7, 4'hF, 32'h01020304);
        idle(1);
        dut.u_array.mem[7][3] = ~dut.u_array.mem[7][3];
        mem_model[7][3] = ~mem_model[7][3];
        bad_model[7][0] = 1'b1;
        do_read(6'd7);
        do_read(6'd5);
        apply_stimulus(1'b0, 1'b1, 6'd7, 4'b0001, 32'h000000AB, 1'b1, 6'd7);
        do_read(6'd7);
`endif

        // Reset mid-sweep restarts the whole 64-cycle sweep.
        apply_stimulus(1'b1, 1'b0, 6'd0, 4'h0, 32'h0, 1'b0, 6'd0);
        idle(20);
        apply_stimulus(1'b1, 1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd5);
        idle(63);
        apply_stimulus(1'b0, 1'b1, 6'd12, 4'hF, 32'h77777777, 1'b0, 6'd0);
        idle(2);
        do_read(6'd5);
        do_read(6'd12);
        idle(2);

        mon_en = 1'b0;
        check_output("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
